// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the multi-cycle ALU: opcodes, FSM states,
//               and a helper that classifies iterative opcodes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_ADD  = 3'd2,
        OP_MUL  = 3'd3,
        OP_SLTU = 3'd4,
        OP_DIVU = 3'd5,
        OP_SUB  = 3'd6,
        OP_SLT  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Bit n set when opcode n runs through the iterative datapath
    localparam logic [7:0] OP_IS_MULTI = 8'b0010_1000;

    function automatic logic op_is_multi(input alu_op_t op_code);
        return OP_IS_MULTI[op_code];
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mdu_iter.sv
// ============================================================================
// Module      : alu_mdu_iter
// Description : Iterative unsigned multiply (shift-add) / divide (restoring),
//               one bit per cycle, WIDTH cycles from start to done pulse.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_opnd;
    logic               w_div;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;

    // The first iteration runs on the fresh operands in the start cycle,
    // so the final bit lands WIDTH-1 edges after the load edge.
    always_comb begin
        w_hi    = start ? '0     : r_hi;
        w_lo    = start ? a      : r_lo;
        w_opnd  = start ? b      : r_opnd;
        w_div   = start ? is_div : r_div;
        w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_opnd} : '0);
        w_shift = {w_hi, w_lo[WIDTH-1]};
        w_trial = w_shift - {1'b0, w_opnd};
        if (w_div) begin
            w_hi_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_lo_nxt = {w_lo[WIDTH-2:0], ~w_trial[WIDTH]};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], w_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_hi   <= w_hi_nxt;
                r_lo   <= w_lo_nxt;
                r_opnd <= b;
                r_div  <= is_div;
                r_cnt  <= c_CNT_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
                if (r_cnt == c_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign lo   = r_lo;
    assign hi   = r_hi;

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes, iterative
//               MUL/DIVU and a high result word. Define ALU_FLAGS_EN to add
//               the carry/ovf flag outputs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             is_zero,
    output logic             div_zero
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             ovf
`endif
);

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    alu_op_t          w_op;
    logic             w_accept;
    logic             w_start;
    logic             w_load_single;
    logic             w_load_multi;
    logic [WIDTH-1:0] w_alu_res;

    logic             r_divz_pend;
    logic [WIDTH-1:0] r_a_hold;

    logic             w_mdu_done;
    logic [WIDTH-1:0] w_mdu_lo;
    logic [WIDTH-1:0] w_mdu_hi;

    assign w_op = alu_op_t'(op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_BUSY: begin
                if (w_mdu_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_accept = in_valid & in_ready;
        if (w_accept) begin
            w_state_nxt = op_is_multi(w_op) ? ST_BUSY : ST_DONE;
        end
        w_start       = w_accept & op_is_multi(w_op);
        w_load_single = w_accept & ~op_is_multi(w_op);
        w_load_multi  = (r_state == ST_BUSY) & w_mdu_done;
    end

    assign out_valid = (r_state == ST_DONE);

    always_comb begin
        w_alu_res = '0;
        unique case (w_op)
            OP_AND:  w_alu_res = in_a & in_b;
            OP_OR:   w_alu_res = in_a | in_b;
            OP_ADD:  w_alu_res = in_a + in_b;
            OP_SUB:  w_alu_res = in_a - in_b;
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: w_alu_res = '0;
        endcase
    end

    // The divide-by-zero answer is fixed, so only the dividend is kept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_divz_pend <= 1'b0;
            r_a_hold    <= '0;
        end else if (w_start) begin
            r_divz_pend <= (w_op == OP_DIVU) && (in_b == '0);
            r_a_hold    <= in_a;
        end
    end

    alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .is_div (w_op == OP_DIVU),
        .a      (in_a),
        .b      (in_b),
        .done   (w_mdu_done),
        .lo     (w_mdu_lo),
        .hi     (w_mdu_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r        <= '0;
            r_hi     <= '0;
            is_zero  <= 1'b0;
            div_zero <= 1'b0;
        end else if (w_load_single) begin
            r        <= w_alu_res;
            r_hi     <= '0;
            is_zero  <= (w_alu_res == '0);
            div_zero <= 1'b0;
        end else if (w_load_multi) begin
            if (r_divz_pend) begin
                r        <= '1;
                r_hi     <= r_a_hold;
                is_zero  <= 1'b0;
                div_zero <= 1'b1;
            end else begin
                r        <= w_mdu_lo;
                r_hi     <= w_mdu_hi;
                is_zero  <= (w_mdu_lo == '0);
                div_zero <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_add_full;
    logic [WIDTH:0] w_sub_full;
    logic           w_carry;
    logic           w_ovf;

    always_comb begin
        w_add_full = {1'b0, in_a} + {1'b0, in_b};
        w_sub_full = {1'b0, in_a} - {1'b0, in_b};
        w_carry    = 1'b0;
        w_ovf      = 1'b0;
        if (w_op == OP_ADD) begin
            w_carry = w_add_full[WIDTH];
            w_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                      (w_add_full[WIDTH-1] != in_a[WIDTH-1]);
        end else if (w_op == OP_SUB) begin
            w_carry = w_sub_full[WIDTH];
            w_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                      (w_sub_full[WIDTH-1] != in_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (w_load_single) begin
            carry <= w_carry;
            ovf   <= w_ovf;
        end else if (w_load_multi) begin
            carry <= 1'b0;
            ovf   <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc (WIDTH=16): directed table,
//               randomized ops against an arithmetic model, handshake corners.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;

    localparam int W = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    op        = 3'd0;
    logic [W-1:0]  in_a      = '0;
    logic [W-1:0]  in_b      = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  r;
    logic [W-1:0]  r_hi;
    logic          is_zero;
    logic          div_zero;
`ifdef ALU_FLAGS_EN
    logic          carry;
    logic          ovf;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_hi      (r_hi),
        .is_zero   (is_zero),
        .div_zero  (div_zero)
`ifdef ALU_FLAGS_EN
        ,
        .carry     (carry),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] er;
        logic [W-1:0] eh;
        logic         ez;
        logic         edz;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    // Reference: plain integer arithmetic on the operation's definition
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] er, output logic [W-1:0] eh,
                                  output logic ez, output logic edz);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned p;
        er  = '0;
        eh  = '0;
        edz = 1'b0;
        case (o)
            3'd0: er = a & b;
            3'd1: er = a | b;
            3'd2: er = W'((ua + ub) % 65536);
            3'd3: begin p = ua * ub; er = p[15:0]; eh = p[31:16]; end
            3'd4: er = (ua < ub) ? 16'd1 : 16'd0;
            3'd5: begin
                if (ub == 0) begin er = 16'hFFFF; eh = a; edz = 1'b1; end
                else begin er = W'(ua / ub); eh = W'(ua % ub); end
            end
            3'd6: er = W'((ua + 65536 - ub) % 65536);
            default: er = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        endcase
        ez = (er == '0);
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
        return (o == 3'd3 || o == 3'd5) ? W + 1 : 1;
    endfunction

    // Presents one op, returns the number of rising edges from the accept
    // edge (counted as 1) until out_valid, and whether in_ready stayed low.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit rdy_low);
        int guard = 0;
        @(negedge clk);
        op = o; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op   = 3'($urandom);
        in_a = W'($urandom);
        in_b = W'($urandom);
        lat = 1;
        rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [9];
        int           lat;
        bit           rdy_low;
        logic [W-1:0] er, eh;
        logic         ez, edz;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        bit           seen;

        tbl[0] = '{3'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 16'hF0F0, 16'h0FF0, 16'hFFF0, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{3'd6, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{3'd4, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{3'd7, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{3'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0};
        tbl[7] = '{3'd5, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
        tbl[8] = '{3'd5, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r",         32'(r),         32'd0);
        chk("rst_r_hi",      32'(r_hi),      32'd0);
        chk("rst_is_zero",   32'(is_zero),   32'd0);
        chk("rst_div_zero",  32'(div_zero),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, rdy_low);
            chk($sformatf("tbl%0d_lat", i),      32'(lat),      32'(exp_lat(tbl[i].op)));
            chk($sformatf("tbl%0d_r", i),        32'(r),        32'(tbl[i].er));
            chk($sformatf("tbl%0d_r_hi", i),     32'(r_hi),     32'(tbl[i].eh));
            chk($sformatf("tbl%0d_is_zero", i),  32'(is_zero),  32'(tbl[i].ez));
            chk($sformatf("tbl%0d_div_zero", i), 32'(div_zero), 32'(tbl[i].edz));
            if (exp_lat(tbl[i].op) > 1)
                chk($sformatf("tbl%0d_busy_in_ready_low", i), 32'(rdy_low), 32'd1);
            take();
            chk($sformatf("tbl%0d_valid_drop", i), 32'(out_valid), 32'd0);
        end

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(ro, ra, rb, er, eh, ez, edz);
            issue(ro, ra, rb, lat, rdy_low);
            chk($sformatf("rnd%0d_op%0d_lat", i, ro),  32'(lat),      32'(exp_lat(ro)));
            chk($sformatf("rnd%0d_op%0d_r", i, ro),    32'(r),        32'(er));
            chk($sformatf("rnd%0d_op%0d_r_hi", i, ro), 32'(r_hi),     32'(eh));
            chk($sformatf("rnd%0d_op%0d_zero", i, ro), 32'(is_zero),  32'(ez));
            chk($sformatf("rnd%0d_op%0d_dz", i, ro),   32'(div_zero), 32'(edz));
            take();
        end

        // Backpressure, then a take and a new accept on the same edge
        issue(3'd2, 16'h1234, 16'h1111, lat, rdy_low);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_r", k),         32'(r),         32'h2345);
            chk($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
        end
        op = 3'd1; in_a = 16'h00FF; in_b = 16'hFF00; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_in_ready_on_take", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        chk("bp_new_r",     32'(r),         32'hFFFF);

        // Take plus same-edge MUL accept: DONE straight to BUSY
        @(negedge clk);
        op = 3'd3; in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("chain_valid_low", 32'(out_valid), 32'd0);
        chk("chain_busy_ready", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("chain_lat", 32'(lat), 32'(W + 1));
        chk("chain_r",   32'(r),   32'd15);
        take();

        // Reset at cycle 8 of a MUL aborts it
        @(negedge clk);
        op = 3'd3; in_a = 16'h00FF; in_b = 16'h0101; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_r",         32'(r),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

`ifdef ALU_FLAGS_EN
        issue(3'd2, 16'h7FFF, 16'h0001, lat, rdy_low);
        chk("flag_add_ovf",   32'(ovf),   32'd1);
        chk("flag_add_carry", 32'(carry), 32'd0);
        take();
        issue(3'd2, 16'hFFFF, 16'h0002, lat, rdy_low);
        chk("flag_add2_carry", 32'(carry), 32'd1);
        chk("flag_add2_ovf",   32'(ovf),   32'd0);
        take();
        issue(3'd6, 16'h8000, 16'h0001, lat, rdy_low);
        chk("flag_sub_ovf",   32'(ovf),   32'd1);
        chk("flag_sub_carry", 32'(carry), 32'd0);
        take();
        issue(3'd6, 16'h0000, 16'h0001, lat, rdy_low);
        chk("flag_sub2_carry", 32'(carry), 32'd1);
        take();
        issue(3'd3, 16'hFFFF, 16'hFFFF, lat, rdy_low);
        chk("flag_mul_carry", 32'(carry), 32'd0);
        chk("flag_mul_ovf",   32'(ovf),   32'd0);
        take();
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
